// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider. Each channel divides clk by its own ratio,
// with near-50% or single-pulse duty; new settings are adopted only at period boundaries.
module clk_div_multi #(
  parameter int NCH   = 4,
  parameter int DIV_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*DIV_W-1:0] div_num,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH-1:0]       en,
  input  logic                 sync,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       upd_ack
);

  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);
  localparam logic [DIV_W:0]   ONE_X = (DIV_W+1)'(1);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DIV_W-1:0] r_act_q, r_act_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             mode_act_q, mode_act_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic [DIV_W-1:0] r_in, r_new;
    logic [DIV_W:0]   high_t, cnt_nxt;
    logic             running, load;

    always_comb begin
      r_in       = div_num[i*DIV_W +: DIV_W];
      running    = (r_act_q >= TWO);
      // A stopped channel re-evaluates its settings on every edge.
      load       = !running || sync || (cnt_q == r_act_q - ONE);
      high_t     = mode_act_q ? ONE_X : (({1'b0, r_act_q} + ONE_X) >> 1);
      cnt_nxt    = {1'b0, cnt_q} + ONE_X;
      r_new      = (en[i] && (r_in >= TWO)) ? r_in : '0;

      r_act_d    = r_act_q;
      mode_act_d = mode_act_q;
      cnt_d      = cnt_q;
      clk_d      = 1'b0;
      tick_d     = 1'b0;
      ack_d      = 1'b0;

      if (load) begin
        r_act_d    = r_new;
        mode_act_d = mode[i];
        cnt_d      = '0;
        clk_d      = (r_new >= TWO);
        tick_d     = (r_new >= TWO);
        ack_d      = (r_new != r_act_q) || (mode[i] != mode_act_q);
      end else begin
        cnt_d      = cnt_nxt[DIV_W-1:0];
        clk_d      = (cnt_nxt < high_t);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_act_q    <= '0;
        mode_act_q <= 1'b0;
        cnt_q      <= '0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
        ack_q      <= 1'b0;
      end else begin
        r_act_q    <= r_act_d;
        mode_act_q <= mode_act_d;
        cnt_q      <= cnt_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
        ack_q      <= ack_d;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign upd_ack[i] = ack_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: ratios, duty modes, boundary-only updates, stop, sync, reset.
module tb_clk_div_multi;

  localparam int NCH   = 4;
  localparam int DIV_W = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH*DIV_W-1:0] div_num;
  logic [NCH-1:0]       mode;
  logic [NCH-1:0]       en;
  logic                 sync;
  logic [NCH-1:0]       clk_out;
  logic [NCH-1:0]       tick;
  logic [NCH-1:0]       upd_ack;

  int vectors     = 0;
  int miscompares = 0;

  clk_div_multi #(.NCH(NCH), .DIV_W(DIV_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .div_num (div_num),
    .mode    (mode),
    .en      (en),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick),
    .upd_ack (upd_ack)
  );

  always #5 clk = ~clk;

  task automatic idle_all();
    en      = '0;
    div_num = '0;
    mode    = '0;
    sync    = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    div_num = '0;
    mode    = '0;
    en      = '0;
    sync    = 1'b0;
    #12;
    vectors++;
    if ({clk_out, tick, upd_ack} !== '0) begin
      miscompares++;
      $display("FAIL reset_hold got clk_out=%b tick=%b upd_ack=%b want all 0", clk_out, tick, upd_ack);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({clk_out, tick, upd_ack} !== '0) begin
        miscompares++;
        $display("FAIL reset_idle cyc%0d got clk_out=%b tick=%b upd_ack=%b want all 0", k, clk_out, tick, upd_ack);
      end
    end
  endtask

  task automatic test_basic();
    string ec, et, eu;
    logic [2:0] want;
    div_num[7:0] = 8'd4;
    mode[0]      = 1'b0;
    en[0]        = 1'b1;
    ec = "11001100";
    et = "10001000";
    eu = "10000000";
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      want = {ec[k] == "1", et[k] == "1", eu[k] == "1"};
      if ({clk_out[0], tick[0], upd_ack[0]} !== want) begin
        miscompares++;
        $display("FAIL basic_r4 cyc%0d got clk/tick/ack=%b want %b", k, {clk_out[0], tick[0], upd_ack[0]}, want);
      end
    end
    div_num[7:0] = 8'd5;
    ec = "1110011100";
    et = "1000010000";
    eu = "1000000000";
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      want = {ec[k] == "1", et[k] == "1", eu[k] == "1"};
      if ({clk_out[0], tick[0], upd_ack[0]} !== want) begin
        miscompares++;
        $display("FAIL basic_r5 cyc%0d got clk/tick/ack=%b want %b", k, {clk_out[0], tick[0], upd_ack[0]}, want);
      end
    end
  endtask

  task automatic test_pulse();
    string ec, eu;
    logic [2:0] want;
    div_num[15:8] = 8'd3;
    mode[1]       = 1'b1;
    en[1]         = 1'b1;
    ec = "100100100";
    eu = "100000000";
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      want = {ec[k] == "1", ec[k] == "1", eu[k] == "1"};
      if ({clk_out[1], tick[1], upd_ack[1]} !== want) begin
        miscompares++;
        $display("FAIL pulse_r3 cyc%0d got clk/tick/ack=%b want %b", k, {clk_out[1], tick[1], upd_ack[1]}, want);
      end
    end
  endtask

  task automatic test_glitch_free();
    string ec, et, eu;
    logic [2:0] want;
    div_num[7:0] = 8'd8;
    mode[0]      = 1'b0;
    en[0]        = 1'b1;
    ec = "11110000110110";
    et = "10000000100100";
    eu = "10000000100000";
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      want = {ec[k] == "1", et[k] == "1", eu[k] == "1"};
      if ({clk_out[0], tick[0], upd_ack[0]} !== want) begin
        miscompares++;
        $display("FAIL glitch_free cyc%0d got clk/tick/ack=%b want %b", k, {clk_out[0], tick[0], upd_ack[0]}, want);
      end
      if (k == 2) div_num[7:0] = 8'd3;
    end
  endtask

  task automatic test_stop();
    string ec, et, eu;
    logic [2:0] want;
    ec = "1110000000";
    et = "1000000000";
    eu = "1000001000";
    for (int v = 0; v < 2; v++) begin
      div_num[23:16] = 8'd6;
      mode[2]        = 1'b0;
      en[2]          = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk);
        #1;
        vectors++;
        want = {ec[k] == "1", et[k] == "1", eu[k] == "1"};
        if ({clk_out[2], tick[2], upd_ack[2]} !== want) begin
          miscompares++;
          $display("FAIL stop_%s cyc%0d got clk/tick/ack=%b want %b", (v == 0) ? "en" : "ratio1",
                   k, {clk_out[2], tick[2], upd_ack[2]}, want);
        end
        if (k == 1) begin
          if (v == 0) en[2] = 1'b0;
          else        div_num[23:16] = 8'd1;
        end
      end
    end
  endtask

  task automatic test_sync();
    string c0, t0, c1, t1;
    logic [6:0] want, got;
    div_num[7:0] = 8'd4;
    en[0]        = 1'b1;
    @(posedge clk);
    #1;
    div_num[15:8] = 8'd6;
    en[1]         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sync = 1'b1;
    c0 = "110011001100";
    t0 = "100010001000";
    c1 = "111000111000";
    t1 = "100000100000";
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) sync = 1'b0;
      vectors++;
      want = {c0[k] == "1", t0[k] == "1", c1[k] == "1", t1[k] == "1", 3'b000};
      got  = {clk_out[0], tick[0], clk_out[1], tick[1], upd_ack[0], upd_ack[1], clk_out[2]};
      if (got !== want) begin
        miscompares++;
        $display("FAIL sync_align cyc%0d got clk0/tick0/clk1/tick1/ack0/ack1/clk2=%b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    div_num = {8'd3, 8'd6, 8'd5, 8'd4};
    mode    = '0;
    en      = '1;
    @(posedge clk);
    #1;
    vectors++;
    if ({clk_out, tick, upd_ack} !== {4'hF, 4'hF, 4'hF}) begin
      miscompares++;
      $display("FAIL all_start got clk_out=%b tick=%b upd_ack=%b want 1111 1111 1111", clk_out, tick, upd_ack);
    end
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (clk_out[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_ch0 got clk_out[0]=%b want 1", clk_out[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({clk_out, tick, upd_ack} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got clk_out=%b tick=%b upd_ack=%b want all 0", clk_out, tick, upd_ack);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({clk_out, tick, upd_ack} !== '0) begin
      miscompares++;
      $display("FAIL reset_held got clk_out=%b tick=%b upd_ack=%b want all 0", clk_out, tick, upd_ack);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({clk_out, tick, upd_ack} !== {4'hF, 4'hF, 4'hF}) begin
      miscompares++;
      $display("FAIL restart got clk_out=%b tick=%b upd_ack=%b want 1111 1111 1111", clk_out, tick, upd_ack);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({clk_out, tick, upd_ack} !== {4'hF, 4'h0, 4'h0}) begin
      miscompares++;
      $display("FAIL restart_2nd got clk_out=%b tick=%b upd_ack=%b want 1111 0000 0000", clk_out, tick, upd_ack);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    idle_all();
    test_pulse();
    idle_all();
    test_glitch_free();
    idle_all();
    test_stop();
    idle_all();
    test_sync();
    idle_all();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
